// File: rtl/uart_prog_loader_if.sv
// rtl/uart_prog_loader_if.sv - byte stream in, instruction-memory write bus and CPU hold out
interface uart_prog_loader_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              restart;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;

    modport master (
        input  rx_data, rx_valid, restart,
        output imem_we, imem_addr, imem_wdata, cpu_hold, load_done
    );

    modport slave (
        output rx_data, rx_valid, restart,
        input  imem_we, imem_addr, imem_wdata, cpu_hold, load_done
    );
endinterface

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - packs UART bytes into little-endian words and loads instruction memory
module uart_prog_loader #(
    parameter int CELL_NUMBERS = 64,
    parameter int ADDR_W       = 6
) (
    input  logic               clk,
    input  logic               rst,
    uart_prog_loader_if.master bus
);
    typedef enum logic [1:0] {LOAD, WRITE, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELL_NUMBERS - 1);

    state_t            state, state_n;
    logic [1:0]        byte_cnt, byte_cnt_n;
    logic [ADDR_W-1:0] word_addr, word_addr_n;
    logic [31:0]       shift, shift_n;
    logic              imem_we, imem_we_n;
    logic [ADDR_W-1:0] imem_addr, imem_addr_n;
    logic [31:0]       imem_wdata, imem_wdata_n;
    logic              cpu_hold, cpu_hold_n;
    logic              load_done, load_done_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LOAD;
            byte_cnt   <= 2'd0;
            word_addr  <= '0;
            shift      <= 32'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
        end else begin
            state      <= state_n;
            byte_cnt   <= byte_cnt_n;
            word_addr  <= word_addr_n;
            shift      <= shift_n;
            imem_we    <= imem_we_n;
            imem_addr  <= imem_addr_n;
            imem_wdata <= imem_wdata_n;
            cpu_hold   <= cpu_hold_n;
            load_done  <= load_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        byte_cnt_n   = byte_cnt;
        word_addr_n  = word_addr;
        shift_n      = shift;
        imem_we_n    = 1'b0;
        imem_addr_n  = imem_addr;
        imem_wdata_n = imem_wdata;
        cpu_hold_n   = cpu_hold;
        load_done_n  = load_done;

        if (bus.restart) begin
            state_n     = LOAD;
            byte_cnt_n  = 2'd0;
            word_addr_n = '0;
            shift_n     = 32'd0;
            cpu_hold_n  = 1'b1;
            load_done_n = 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (bus.rx_valid) begin
                        shift_n[{byte_cnt, 3'b000} +: 8] = bus.rx_data;
                        if (byte_cnt == 2'd3) begin
                            state_n      = WRITE;
                            imem_we_n    = 1'b1;
                            imem_addr_n  = word_addr;
                            imem_wdata_n = {bus.rx_data, shift[23:0]};
                        end else begin
                            byte_cnt_n = byte_cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    if (word_addr == LAST_ADDR) begin
                        state_n     = RUN;
                        cpu_hold_n  = 1'b0;
                        load_done_n = 1'b1;
                    end else begin
                        state_n     = LOAD;
                        word_addr_n = word_addr + 1'b1;
                        // a byte landing in the write cycle opens the next word
                        if (bus.rx_valid) begin
                            shift_n[7:0] = bus.rx_data;
                            byte_cnt_n   = 2'd1;
                        end else begin
                            byte_cnt_n = 2'd0;
                        end
                    end
                end
                RUN: ;
                default: state_n = LOAD;
            endcase
        end
    end

    assign bus.imem_we    = imem_we;
    assign bus.imem_addr  = imem_addr;
    assign bus.imem_wdata = imem_wdata;
    assign bus.cpu_hold   = cpu_hold;
    assign bus.load_done  = load_done;
endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Program loader between the UART receiver and the CPU's instruction memory. Assembles received bytes into 32-bit little-endian words and writes them to consecutive instruction-memory cells. Holds the CPU in reset until `CELL_NUMBERS` words are written, then releases it. Feeds the `cpu_uart_top` load phase; the CPU executes only after this block asserts `load_done`.

## Interface

Parameters:

- `CELL_NUMBERS`, 64 — number of 32-bit words per program image; must be ≥ 1.
- `ADDR_W`, 6 — instruction-memory word-address width; 2^`ADDR_W` ≥ `CELL_NUMBERS`.

Ports:

- `clk`  in  1  — single clock; all state changes on its rising edge.
- `rst`  in  1  — reset, asynchronous, active-low.
- `rx_data`  in  8  — received byte; valid only when `rx_valid` is 1.
- `rx_valid`  in  1  — one-cycle strobe per received byte.
- `restart`  in  1  — synchronous pulse; discards progress and reloads from word 0.
- `imem_we`  out  1  — instruction-memory write enable, one cycle per word.
- `imem_addr`  out  `ADDR_W`  — word address of the current write.
- `imem_wdata`  out  32  — assembled word.
- `cpu_hold`  out  1  — active-high CPU reset/hold; 1 while loading.
- `load_done`  out  1  — 1 once the full image is written.

## Operation

- All outputs are registered.
- States:
  - `LOAD` — collecting bytes.
  - `WRITE` — one-cycle memory write.
  - `RUN` — image complete.
- Internal state:
  - `byte_cnt` (2 bits)
  - `word_addr` (`ADDR_W` bits)
  - `shift` (32-bit assembly register)
- Reset (`rst` = 0):
  - State goes to `LOAD`; `byte_cnt` = 0; `word_addr` = 0; `shift` = 0.
  - Outputs: `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0, `cpu_hold` = 1, `load_done` = 0.
- `LOAD`: on `rx_valid`, write `rx_data` into `shift[8*byte_cnt +: 8]`; little-endian, so the first byte goes to bits 7:0.
  - If `byte_cnt` was 3: go to `WRITE` and register `imem_we` = 1, `imem_addr` = `word_addr`, `imem_wdata` = completed word.
  - Otherwise increment `byte_cnt`.
- `WRITE` (exactly one cycle): `imem_we` returns to 0 next cycle.
  - If `word_addr` == `CELL_NUMBERS`−1: go to `RUN`, `cpu_hold` ← 0, `load_done` ← 1.
  - Otherwise: `word_addr` +1, `byte_cnt` ← 0, go to `LOAD`.
  - A `rx_valid` arriving during `WRITE` is not dropped when another word follows. It is stored as byte 0 of the next word and `byte_cnt` becomes 1.
  - On the final word, that byte is discarded.
- `RUN`: `rx_valid` is ignored. `cpu_hold` stays 0 and `load_done` stays 1 until `restart` or reset.
- `restart` has priority over all other events in every state. Next cycle:
  - State is `LOAD`; `byte_cnt` = 0; `word_addr` = 0; `shift` = 0.
  - Outputs: `imem_we` = 0, `cpu_hold` = 1, `load_done` = 0.
  - A pending `WRITE` is cancelled and a coincident `rx_valid` is discarded.
- `imem_addr` and `imem_wdata` hold their last values when `imem_we` = 0.
- `word_addr` never exceeds `CELL_NUMBERS`−1; there is no wrap-around.

## Timing

- `imem_we` is high in the cycle after the edge that samples the 4th byte of a word. It lasts exactly one cycle.
- Final word: `cpu_hold` falls and `load_done` rises on the edge that ends the final `imem_we` cycle. This is 2 edges after the last byte is sampled.
- Total load time is 4×`CELL_NUMBERS` accepted strobes. Minimum is 4×`CELL_NUMBERS`+1 cycles with back-to-back `rx_valid`.
- Sustained throughput is one byte per cycle; no stall path exists and there is no ready output.
- Async reset takes effect immediately, mid-cycle included. All outputs reach their reset values without waiting for `clk`. Release is sampled on the next `clk` rising edge.

## Test plan

- **Reset values:** hold `rst` = 0 with no clock edges, then check `cpu_hold` = 1, `load_done` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
- **Single word** (`CELL_NUMBERS` = 4): send 0x93, 0x00, 0x10, 0x00 spaced 3 cycles apart.
  - One-cycle `imem_we` with `imem_addr` = 0 and `imem_wdata` = 0x00100093, one cycle after the 4th strobe.
- **Back-to-back:** `rx_valid` every cycle for 16 bytes 0x00..0x0F (`CELL_NUMBERS` = 4).
  - Writes 0x03020100 @0, 0x07060504 @1, 0x0B0A0908 @2, 0x0F0E0D0C @3; no bytes lost across `WRITE` cycles.
- **Image complete:** after word 3, `cpu_hold` goes 1→0 and `load_done` goes 0→1 exactly one cycle after the final `imem_we`.
  - Extra bytes sent afterward cause no `imem_we`.
- **Restart mid-load:** send 2 bytes, pulse `restart`, then send 0xEF, 0xBE, 0xAD, 0xDE.
  - Write @0 = 0xDEADBEEF. Repeating `restart` in `RUN` re-asserts `cpu_hold` = 1 next cycle.
- **Async reset mid-write:** drop `rst` between edges while `imem_we` = 1.
  - `imem_we` = 0 and `cpu_hold` = 1 immediately. After release, the next 4 bytes write to address 0.
